// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage.
//   - fetch_state_e : fetch controller states (idle / running / halted)
//   - fetch_entry_t : one fetch-queue entry, {pc, instr}
//   - FETCH_RESET_PC, FETCH_HALT_WORD, PC_STEP : default constants
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam logic [31:0] FETCH_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] FETCH_HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] PC_STEP         = 32'd4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalted
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
// Two-entry FIFO holding fetched {pc, instr} pairs. The head entry is a
// register that drives the consumer directly, so outputs are registered.
// An empty head is held at zero.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   push         enqueue push_entry (ignored when full unless popping too)
//   push_entry   entry to enqueue
//   pop          dequeue head (ignored when empty)
//   flush        drop both entries; overrides push and pop
//   head         current head entry (zero when empty)
//   full, empty  occupancy flags
// ----------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    fetch_entry_t head_q, head_d;
    fetch_entry_t tail_q, tail_d;
    logic         head_valid_q, head_valid_d;
    logic         tail_valid_q, tail_valid_d;
    logic         do_push;
    logic         do_pop;

    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        head_valid_d = head_valid_q;
        tail_valid_d = tail_valid_q;

        do_pop  = pop && head_valid_q;
        // A pop in the same cycle frees a slot for a push into a full queue.
        do_push = push && (!tail_valid_q || do_pop);

        if (flush) begin
            head_d       = '0;
            tail_d       = '0;
            head_valid_d = 1'b0;
            tail_valid_d = 1'b0;
        end else if (!head_valid_q) begin
            if (do_push) begin
                head_d       = push_entry;
                head_valid_d = 1'b1;
            end
        end else if (!tail_valid_q) begin
            if (do_pop && do_push) begin
                head_d = push_entry;
            end else if (do_pop) begin
                head_d       = '0;
                head_valid_d = 1'b0;
            end else if (do_push) begin
                tail_d       = push_entry;
                tail_valid_d = 1'b1;
            end
        end else begin
            if (do_pop) begin
                head_d = tail_q;
                if (do_push) begin
                    tail_d = push_entry;
                end else begin
                    tail_d       = '0;
                    tail_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            head_valid_q <= 1'b0;
            tail_valid_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            head_valid_q <= head_valid_d;
            tail_valid_q <= tail_valid_d;
        end
    end

    assign head  = head_q;
    assign full  = tail_valid_q;
    assign empty = !head_valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage: owns the PC, addresses instruction memory (combinational read),
// and queues each returned word with its PC in a 2-entry fetch queue that
// feeds decode over valid/ready. Redirects flush the queue and reload the PC;
// fetching a HALT_WORD stops fetch until the next redirect.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   fetch_en         leave IDLE and start fetching (sampled only in IDLE)
//   imem_addr        byte address to instruction memory (always the PC)
//   imem_data        word read at imem_addr, same cycle
//   redirect_valid   branch/jump taken this cycle
//   redirect_target  new PC, low two bits forced to zero
//   out_valid        head of queue holds an instruction
//   out_ready        decode accepts the head this cycle
//   out_instr        head instruction (zero when empty)
//   out_pc           PC of head instruction (zero when empty)
//   halted           fetch is stopped on a halt word
// ----------------------------------------------------------------------------
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
    parameter logic [31:0] HALT_WORD = FETCH_HALT_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;

    logic         q_push;
    logic         q_pop;
    logic         q_flush;
    logic         q_full;
    logic         q_empty;
    fetch_entry_t q_in;
    fetch_entry_t q_head;
    logic         is_halt;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;

        is_halt = (imem_data == HALT_WORD);
        q_pop   = out_valid && out_ready;
        // IDLE never holds queue entries, so a redirect there only loads the PC.
        q_flush = redirect_valid && (state_q != StIdle);
        q_push  = (state_q == StRun) && !redirect_valid && (!q_full || q_pop);
        q_in    = '{pc: pc_q, instr: imem_data};

        case (state_q)
            StIdle: begin
                if (fetch_en) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (q_push && is_halt) begin
                    state_d = StHalted;
                end
            end
            StHalted: begin
                if (redirect_valid) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase

        if (redirect_valid) begin
            pc_d = redirect_target & ~32'h3;
        end else if (q_push && !is_halt) begin
            // Halt word is queued but the PC stays on its address.
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_queue u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (q_push),
        .push_entry (q_in),
        .pop        (q_pop),
        .flush      (q_flush),
        .head       (q_head),
        .full       (q_full),
        .empty      (q_empty)
    );

    assign imem_addr = pc_q;
    assign out_valid = !q_empty;
    assign out_instr = q_head.instr;
    assign out_pc    = q_head.pc;
    assign halted    = (state_q == StHalted);

endmodule

// File: tb/tb_instruction_fetch.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a queue-based reference model of the fetch stage.
// ----------------------------------------------------------------------------
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;

    // Memory content: word k (address 4k) holds (k+1)*0x11, optionally one
    // address overridden with the halt word.
    logic        halt_en;
    logic [31:0] halt_addr;

    int compared   = 0;
    int mismatched = 0;

    localparam int MIdle = 0;
    localparam int MRun  = 1;
    localparam int MHalt = 2;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic [31:0] m_pc;
    int          m_mode;
    logic [63:0] m_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] k;
        k = {2'b00, a[31:2]} + 32'd1;
        return k * 32'h11;
    endfunction

    function automatic logic [31:0] mem_at(input logic [31:0] a);
        return (halt_en && a == halt_addr) ? HALT : mem_word(a);
    endfunction

    assign imem_data = (halt_en && imem_addr == halt_addr) ? HALT : mem_word(imem_addr);

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_en        (fetch_en),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .halted          (halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        logic [63:0] head;
        head = (m_q.size() != 0) ? m_q[0] : 64'h0;
        check("imem_addr", imem_addr, m_pc);
        check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        check("out_pc", out_pc, head[63:32]);
        check("out_instr", out_instr, head[31:0]);
        check("halted", 32'(halted), 32'(m_mode == MHalt));
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic [31:0] w;
        if (m_mode == MIdle) begin
            if (redirect_valid) m_pc = redirect_target & 32'hFFFF_FFFC;
            if (fetch_en) m_mode = MRun;
        end else if (redirect_valid) begin
            m_q.delete();
            m_pc   = redirect_target & 32'hFFFF_FFFC;
            m_mode = MRun;
        end else begin
            if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
            if (m_mode == MRun && m_q.size() < 2) begin
                w = mem_at(m_pc);
                m_q.push_back({m_pc, w});
                if (w == HALT) m_mode = MHalt;
                else m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic model_reset();
        m_pc   = 32'h0;
        m_mode = MIdle;
        m_q.delete();
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    // Assert reset between edges; outputs must clear without a clock.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_model();
    endtask

    initial begin
        reset           = 1'b1;
        fetch_en        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        out_ready       = 1'b0;
        halt_en         = 1'b0;
        halt_addr       = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        reset = 1'b0;
        tick();

        // Basic fetch: first valid two cycles after fetch_en.
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        tick();
        fetch_en = 1'b0;
        check("idle_no_valid", 32'(out_valid), 32'h0);
        tick();
        check("first_pc", out_pc, 32'h0);
        check("first_instr", out_instr, 32'h11);
        tick();
        check("second_instr", out_instr, 32'h22);
        tick();
        check("third_pc", out_pc, 32'h8);
        check("third_instr", out_instr, 32'h33);

        // Reset mid-burst.
        do_reset();

        // Backpressure: two entries, PC held at 0x8.
        fetch_en  = 1'b1;
        out_ready = 1'b0;
        tick();
        fetch_en = 1'b0;
        repeat (5) tick();
        check("bp_addr_held", imem_addr, 32'h8);
        check("bp_head", out_pc, 32'h0);
        out_ready = 1'b1;
        tick();
        check("bp_release1", out_pc, 32'h4);
        tick();
        check("bp_release2", out_pc, 32'h8);

        // Redirect with a full queue.
        out_ready = 1'b0;
        repeat (3) tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h103;
        tick();
        redirect_valid = 1'b0;
        check("redir_flush", 32'(out_valid), 32'h0);
        tick();
        check("redir_valid", 32'(out_valid), 32'h1);
        check("redir_pc", out_pc, 32'h100);
        check("redir_instr", out_instr, mem_word(32'h100));

        // Redirect and pop together with two entries.
        repeat (2) tick();
        out_ready       = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        tick();
        redirect_valid = 1'b0;
        check("redir_pop_empty", 32'(out_valid), 32'h0);

        // Halt word at 0xC.
        do_reset();
        halt_en   = 1'b1;
        halt_addr = 32'hC;
        fetch_en  = 1'b1;
        tick();
        fetch_en = 1'b0;
        repeat (4) tick();
        check("halt_flag", 32'(halted), 32'h1);
        check("halt_pc", out_pc, 32'hC);
        check("halt_instr", out_instr, HALT);
        repeat (10) tick();
        check("halt_pc_frozen", imem_addr, 32'hC);
        check("halt_drained", 32'(out_valid), 32'h0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("resume_pc", out_pc, 32'h40);
        check("resume_halted", 32'(halted), 32'h0);

        // PC wrap.
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_addr_zero", imem_addr, 32'h0);

        // Randomized traffic.
        halt_addr = 32'h18;
        for (int i = 0; i < 800; i++) begin
            fetch_en        = ($urandom % 4) == 0;
            out_ready       = ($urandom % 4) != 0;
            redirect_valid  = ($urandom % 12) == 0;
            redirect_target = ($urandom % 2) ? $urandom : $urandom_range(0, 63);
            if ($urandom % 40 == 0) halt_addr = 32'($urandom_range(0, 15)) << 2;
            if ($urandom % 250 == 0) do_reset();
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the single-cycle/pipelined CPU: owns the program counter, drives the byte address into `instructionmemory` (combinational read, word-indexed by `address >> 2`), and captures each returned word with its PC into a 2-entry fetch queue. It presents instructions to the decode stage over a valid/ready handshake. It accepts redirects (branch/jump) that flush the queue, and halts on a designated halt word.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `HALT_WORD`, 32'hFFFF_FFFF, instruction encoding that stops fetch.
- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-high; all state cleared immediately on assertion.
- `fetch_en`  in  1  start/permit fetching from IDLE.
- `imem_addr`  out  32  byte address to `instructionmemory.address`; always equals current PC.
- `imem_data`  in  32  word from `instructionmemory.dataOut`, valid same cycle as `imem_addr`.
- `redirect_valid`  in  1  branch/jump taken this cycle.
- `redirect_target`  in  32  new PC; bits [1:0] ignored (forced 00).
- `out_valid`  out  1  queue head holds a valid instruction.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_instr`  out  32  head instruction.
- `out_pc`  out  32  PC of head instruction.
- `halted`  out  1  high while in HALTED.

## Operation
- States: IDLE, RUN, HALTED.
  - IDLE: no enqueue. `fetch_en`=1 -> RUN next cycle.
  - RUN: each cycle with queue not full (or a pop this cycle making room), enqueue {PC, `imem_data`}, PC <= PC + 4 (mod 2^32, wraps to 0). If the enqueued word equals `HALT_WORD`, it is still enqueued, PC does not advance, and state -> HALTED.
  - HALTED: no enqueue; queue drains normally. `redirect_valid` -> RUN with PC = target.
  - `fetch_en` is only sampled in IDLE; deasserting it in RUN has no effect.
- Queue: 2 entries, FIFO order, registered outputs. `out_*` are driven from the head; `out_instr`/`out_pc` are don't-care but held at 0 when empty.
- Pop when `out_valid && out_ready`. Push and pop may occur in the same cycle; with a full queue, a same-cycle pop permits a push.
- Redirect (any state except IDLE, where it loads PC but stays IDLE): queue flushed (both entries invalid, including the head even if popped this cycle). PC <= {target[31:2], 2'b00}. No enqueue that cycle. Redirect wins over push, pop, and halt detection.
- Reset values: PC = `RESET_PC`, state IDLE, queue empty, `out_valid`=0, `out_instr`=0, `out_pc`=0, `halted`=0, `imem_addr`=`RESET_PC`.

## Timing
- Fetch latency: word addressed in cycle N appears on `out_*` with `out_valid`=1 in cycle N+1 (queue was empty).
- Throughput: 1 instruction/cycle with `out_ready` held high.
- Backpressure: with `out_ready`=0, the queue fills after 2 pushes; PC then holds, and `imem_addr` is stable until a pop occurs.
- Redirect at cycle N: `out_valid`=0 at N+1; first instruction from target valid at N+2.
- IDLE->RUN: `fetch_en` at N, first push at N+1, `out_valid` at N+2.
- HALT word pushed at N: `halted`=1 from N+1; PC frozen at the halt word's address.
- Reset asserted mid-operation: outputs take reset values asynchronously; the in-flight handshake is dropped.

## Structure
- `fetch_pkg`: state enum (IDLE/RUN/HALTED), `PC_STEP` = 4, and the queue-entry struct {pc[31:0], instr[31:0]}.
- Sub-module `fetch_queue`: 2-entry FIFO with push/pop/flush ports and full/empty flags. `instruction_fetch` holds the PC, the FSM, and the redirect logic.

## Test plan
- Reset, `fetch_en`=1, memory words 0x11,0x22,0x33 at 0x0/0x4/0x8, `out_ready`=1 -> out sequence (pc,instr) = (0,0x11),(4,0x22),(8,0x33), first valid 2 cycles after `fetch_en`.
- `out_ready`=0 for 5 cycles from RUN -> exactly 2 entries queued, `imem_addr` held at 0x8. Release -> 0x0,0x4,0x8 delivered in order, with no loss or duplication.
- Redirect to 0x103 while the queue is full -> next `out_valid` is 2 cycles later with `out_pc`=0x100. The old entries are never presented.
- `HALT_WORD` at 0xC -> instr at 0xC delivered, `halted`=1, no further pushes for 10 cycles. Redirect to 0x40 -> resumes RUN at 0x40.
- PC=0xFFFF_FFFC fetched -> next `imem_addr`=0x0000_0000.
- Redirect and pop in the same cycle with 2 entries -> queue empty next cycle. Reset asserted mid-burst -> `out_valid`=0 immediately and PC=`RESET_PC`.
